store_unit: RTL and testbench

//   Write side of the data-memory interface: the counterpart of the instruction/accumulator

---
 rtl/store_unit_pkg.sv | 17 +
 rtl/store_queue.sv | 59 +++++
 rtl/store_unit.sv | 151 +++++++++++++++
 tb/tb_store_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/store_unit_pkg.sv
// Shared definitions for the data-memory write path: store FSM encodings and width constants.
package store_unit_pkg;

    localparam int BITS_DEFAULT      = 8;
    localparam int ADDR_BITS_DEFAULT = 8;
    localparam int BITS_IDX          = BITS_DEFAULT - 1;
    localparam int ADDR_IDX          = ADDR_BITS_DEFAULT - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_VERIFY = 3'd4
    } store_state_t;

endpackage

// File: rtl/store_queue.sv
// Parameterised FIFO holding pending stores; exposes the head and the entry behind it.
module store_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Explicit wrap so non-power-of-two depths stay correct too.
    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        return p + PTR_W'(1);
    endfunction

    assign head      = mem[rd_ptr];
    assign head_next = mem[inc(rd_ptr)];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= inc(wr_ptr);
            if (pop)
                rd_ptr <= inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/store_unit.sv
// RAM write sequencer: queues stores and drives setup/strobe/hold on the shared bus.
// Optional readback check after each write is enabled by defining STORE_VERIFY_EN.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int BITS          = 8,
    parameter int ADDR_BITS     = 8,
    parameter int QUEUE_DEPTH   = 2,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [BITS-1:0]      req_data,
    output logic                 req_ready,
    output logic                 bus_req,
    input  logic                 bus_grant,
    output logic [ADDR_BITS-1:0] address,
    output logic [BITS-1:0]      data_out,
    input  logic [BITS-1:0]      data_in,
    output logic                 mem_we,
    output logic                 idle,
    output logic                 verify_err
);
    localparam int ENTRY_W = ADDR_BITS + BITS;
    localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam int SC_W    = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    store_state_t         state, state_nxt;
    logic [SC_W-1:0]      strobe_cnt, strobe_cnt_nxt;
    logic [ADDR_BITS-1:0] address_nxt;
    logic [BITS-1:0]      data_nxt;
    logic                 we_nxt;
    logic                 pop;
    logic                 store_done;
    logic                 full, empty;
    logic [CNT_W-1:0]     count;
    logic [ENTRY_W-1:0]   head, head_next;

    assign req_ready = !full && !reset;
    assign bus_req   = !empty || (state != ST_IDLE);
    assign idle      = empty && (state == ST_IDLE);

    store_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (req_valid && req_ready),
        .pop       (pop),
        .push_data ({req_addr, req_data}),
        .head      (head),
        .head_next (head_next),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

`ifdef STORE_VERIFY_EN
    logic err_nxt;
`else
    logic verify_unused;
    assign verify_unused = ^data_in;
    assign verify_err    = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        strobe_cnt_nxt = strobe_cnt;
        address_nxt    = address;
        data_nxt       = data_out;
        we_nxt         = 1'b0;
        pop            = 1'b0;
        store_done     = 1'b0;
`ifdef STORE_VERIFY_EN
        err_nxt        = verify_err;
`endif
        case (state)
            ST_IDLE: begin
                if (!empty && bus_grant) begin
                    state_nxt                 = ST_SETUP;
                    {address_nxt, data_nxt}   = head;
                end
            end
            ST_SETUP: begin
                state_nxt      = ST_STROBE;
                strobe_cnt_nxt = SC_W'(STROBE_CYCLES - 1);
                we_nxt         = 1'b1;
            end
            ST_STROBE: begin
                if (strobe_cnt == '0) begin
                    state_nxt = ST_HOLD;
                end else begin
                    strobe_cnt_nxt = strobe_cnt - SC_W'(1);
                    we_nxt         = 1'b1;
                end
            end
            ST_HOLD: begin
`ifdef STORE_VERIFY_EN
                state_nxt = ST_VERIFY;
`else
                store_done = 1'b1;
`endif
            end
`ifdef STORE_VERIFY_EN
            ST_VERIFY: begin
                if (data_in != data_out)
                    err_nxt = 1'b1;
                store_done = 1'b1;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase

        // Head is popped this edge, so a chained write starts from the entry behind it.
        if (store_done) begin
            pop = 1'b1;
            if ((count > CNT_W'(1)) && bus_grant) begin
                state_nxt               = ST_SETUP;
                {address_nxt, data_nxt} = head_next;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            strobe_cnt <= '0;
            address    <= '0;
            data_out   <= '0;
            mem_we     <= 1'b0;
`ifdef STORE_VERIFY_EN
            verify_err <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            strobe_cnt <= strobe_cnt_nxt;
            address    <= address_nxt;
            data_out   <= data_nxt;
            mem_we     <= we_nxt;
`ifdef STORE_VERIFY_EN
            verify_err <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: directed latency/ordering/reset cases plus random traffic vs a write-order model.
module tb_store_unit;
`ifdef STORE_VERIFY_EN
    localparam int VX = 1;
`else
    localparam int VX = 0;
`endif
    localparam int STROBE = 1;

    logic       clk, reset, req_valid, bus_grant;
    logic [7:0] req_addr, req_data, data_in;
    logic       req_ready, bus_req, mem_we, idle, verify_err;
    logic [7:0] address, data_out;

    logic       s3_req_valid;
    logic [7:0] s3_req_addr, s3_req_data;
    logic       s3_req_ready, s3_bus_req, s3_mem_we, s3_idle, s3_unused_err;
    logic [7:0] s3_address, s3_data_out;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ram [256];
    logic [15:0] exp_q [$];
    int          run;
    logic [15:0] run_ent;
    logic        prev_we = 1'b0;

    store_unit #(.BITS(8), .ADDR_BITS(8), .QUEUE_DEPTH(2), .STROBE_CYCLES(STROBE)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .bus_req(bus_req),
        .bus_grant(bus_grant), .address(address), .data_out(data_out),
        .data_in(data_in), .mem_we(mem_we), .idle(idle), .verify_err(verify_err)
    );

    store_unit #(.BITS(8), .ADDR_BITS(8), .QUEUE_DEPTH(2), .STROBE_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(s3_req_valid), .req_addr(s3_req_addr),
        .req_data(s3_req_data), .req_ready(s3_req_ready), .bus_req(s3_bus_req),
        .bus_grant(bus_grant), .address(s3_address), .data_out(s3_data_out),
        .data_in(8'h00), .mem_we(s3_mem_we), .idle(s3_idle), .verify_err(s3_unused_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model; address 0x33 reads back corrupted
    always @(posedge clk) if (mem_we) ram[address] <= data_out;
    assign data_in = ram[address] ^ ((address == 8'h33) ? 8'hFF : 8'h00);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Accepted stores, in order; reset discards everything pending
    always @(posedge clk)
        if (!reset && req_valid && req_ready) exp_q.push_back({req_addr, req_data});

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            run     = 0;
            prev_we = 1'b0;
        end else begin
            if (mem_we && !prev_we) begin
                check("write_has_entry", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("write_order", {address, data_out}, exp_q.pop_front());
                run_ent = {address, data_out};
                run     = 1;
            end else if (mem_we) begin
                run++;
                check("write_stable", {address, data_out}, run_ent);
            end else if (prev_we) begin
                check("strobe_width", run, STROBE);
            end
            prev_we = mem_we;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        check("rst_we", mem_we, 0);
        check("rst_ready_low", req_ready, 0);
        reset = 1'b0;
        #1;
        check("rst_idle", idle, 1);
        check("rst_ready", req_ready, 1);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (!idle && n < lim) begin
            tick();
            n++;
        end
        check("drain_idle", idle, 1);
    endtask

    task automatic push1(input logic [7:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        int hi, first, last, unstable, seen;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; bus_grant = 1'b0;
        s3_req_valid = 1'b0; s3_req_addr = '0; s3_req_data = '0;
        tick();
        check("rst_addr", address, 0);
        check("rst_data", data_out, 0);
        check("rst_busreq", bus_req, 0);
        check("rst_verr", verify_err, 0);
        do_reset();
        check("s3_ready", s3_req_ready, 1);

        // single store latency
        bus_grant = 1'b1;
        push1(8'h05, 8'hA5);
        check("t1_busreq", bus_req, 1);
        tick(); check("t1_setup_we", mem_we, 0); check("t1_setup_addr", address, 8'h05);
        tick(); check("t1_we", mem_we, 1); check("t1_addr", address, 8'h05); check("t1_data", data_out, 8'hA5);
        tick(); check("t1_hold_we", mem_we, 0); check("t1_hold_idle", idle, 0);
        repeat (VX) tick();
        tick(); check("t1_idle", idle, 1);

        // two queued stores, back to back
        req_valid = 1'b1; req_addr = 8'h10; req_data = 8'h11; tick();
        req_addr = 8'h20; req_data = 8'h22; tick();
        req_valid = 1'b0;
        check("t2_full", req_ready, 0);
        tick(); check("t2_we1", mem_we, 1); check("t2_addr1", address, 8'h10);
        tick(); repeat (VX) tick();
        tick(); check("t2_setup2", address, 8'h20); check("t2_setup2_we", mem_we, 0);
        tick(); check("t2_we2", mem_we, 1); check("t2_data2", data_out, 8'h22);
        wait_idle(20);

        // bus withheld
        bus_grant = 1'b0;
        push1(8'h40, 8'h44);
        repeat (4) begin
            tick();
            check("t3_busreq", bus_req, 1);
            check("t3_no_we", mem_we, 0);
        end
        bus_grant = 1'b1;
        tick(); check("t3_setup", address, 8'h40); check("t3_setup_we", mem_we, 0);
        tick(); check("t3_we", mem_we, 1);
        wait_idle(20);

        // reset while strobing
        req_valid = 1'b1; req_addr = 8'h50; req_data = 8'h55; tick();
        req_addr = 8'h60; req_data = 8'h66; tick();
        req_valid = 1'b0;
        tick(); check("t4_we", mem_we, 1);
        do_reset();
        seen = 0;
        repeat (10) begin
            tick();
            seen += int'(mem_we);
        end
        check("t4_no_writes", seen, 0);

        // STROBE_CYCLES=3 instance
        s3_req_valid = 1'b1; s3_req_addr = 8'h77; s3_req_data = 8'h7E; tick();
        s3_req_valid = 1'b0;
        check("s3_busreq", s3_bus_req, 1);
        hi = 0; first = -1; last = -1; unstable = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s3_mem_we) begin
                hi++;
                if (first < 0) first = i;
                last = i;
                if (s3_address != 8'h77 || s3_data_out != 8'h7E) unstable++;
            end
        end
        check("s3_width", hi, 3);
        check("s3_span", last - first + 1, 3);
        check("s3_stable", unstable, 0);
        check("s3_idle", s3_idle, 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = 8'($urandom_range(0, 255));
            if (req_addr == 8'h33) req_addr = 8'h34;
            req_data  = 8'($urandom_range(0, 255));
            bus_grant = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = 1'b0;
        bus_grant = 1'b1;
        wait_idle(100);
        check("rand_drained", exp_q.size(), 0);

`ifdef STORE_VERIFY_EN
        push1(8'h33, 8'h5A);
        wait_idle(20);
        check("t6_err_set", verify_err, 1);
        push1(8'h34, 8'h11);
        wait_idle(20);
        check("t6_err_sticky", verify_err, 1);
        do_reset();
        check("t6_err_clear", verify_err, 0);
`else
        check("verr_tied", verify_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
